// File: rtl/mp2_bitstream_shifter_pkg.sv
// Shared widths for the MP2 bitstream read path.
package mp2_defines;
   localparam int MP2_WORD_W    = 16;
   localparam int MP2_HOLD_W    = 32;
   localparam int MP2_SHIFT_W   = 5;
   localparam int MP2_MAX_SHIFT = 16;
   localparam int MP2_COUNT_W   = 6;   // holds 0..32 valid bits
endpackage

// File: rtl/mp2_bitstream_shifter_if.sv
// Word-buffer handshake between the audio word buffer (master) and the shifter (slave).
interface mp2_bitstream_shifter_if;
   import mp2_defines::*;

   logic [MP2_WORD_W-1:0] Word_Data_I;
   logic                  Word_Valid_I;
   logic                  Word_Ready_O;

   modport master (output Word_Data_I, Word_Valid_I, input  Word_Ready_O);
   modport slave  (input  Word_Data_I, Word_Valid_I, output Word_Ready_O);
endinterface

// File: rtl/mp2_shift_insert.sv
// Next holding-register value: consume shift_n MSBs, then optionally drop a word
// in directly below the bits that remain.
module mp2_shift_insert
   import mp2_defines::*;
(
   input  logic [MP2_HOLD_W-1:0]  hold,
   input  logic [MP2_COUNT_W-1:0] count_after,
   input  logic [MP2_SHIFT_W-1:0] shift_n,
   input  logic [MP2_WORD_W-1:0]  word,
   input  logic                   insert,
   output logic [MP2_HOLD_W-1:0]  next_hold
);
   logic [MP2_HOLD_W-1:0] shifted;
   logic [MP2_HOLD_W-1:0] word_pos;
   logic [MP2_HOLD_W-1:0] mask;

   assign shifted  = hold << shift_n;
   assign word_pos = {word, {MP2_WORD_W{1'b0}}} >> count_after;
   assign mask     = {{MP2_WORD_W{1'b1}}, {MP2_WORD_W{1'b0}}} >> count_after;

   assign next_hold = insert ? ((shifted & ~mask) | word_pos) : shifted;
endmodule

// File: rtl/mp2_bitstream_shifter.sv
// MP2 bitstream read port: 16-bit MSB-first look-ahead window over a 32-bit
// holding register, consuming 1..16 bits per accepted shift.
module mp2_bitstream_shifter
   import mp2_defines::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   Flush_I,
   mp2_bitstream_shifter_if.slave word_bus,
   input  logic [MP2_SHIFT_W-1:0] Shift_En_I,
   output logic                   Shift_Busy_O,
   output logic                   Byte_Allign_O,
   output logic [MP2_WORD_W-1:0]  Bitstream_Data_O,
   output logic                   Empty_O,
   output logic                   Shift_Error_O,
   output logic [CNT_WIDTH-1:0]   Bits_Consumed_O
);
   logic [MP2_HOLD_W-1:0]  hold_q, hold_next;
   logic [MP2_COUNT_W-1:0] count_q, count_after, count_next;
   logic [2:0]             phase_q;
   logic                   busy_q;
   logic                   shift_ok, shift_bad;
   logic [MP2_SHIFT_W-1:0] shift_n;
   logic                   word_ready, refill;

   assign shift_ok  = !busy_q && (Shift_En_I != '0) &&
                      (Shift_En_I <= MP2_SHIFT_W'(MP2_MAX_SHIFT));
   assign shift_bad = !busy_q && (Shift_En_I > MP2_SHIFT_W'(MP2_MAX_SHIFT));
   assign shift_n   = shift_ok ? Shift_En_I : '0;

   // Readiness looks at the count after this cycle's shift so a 16-bit
   // consume and a refill can land on the same edge.
   assign count_after = count_q - MP2_COUNT_W'(shift_n);
   assign word_ready  = !Flush_I && (count_after <= MP2_COUNT_W'(MP2_WORD_W));
   assign refill      = word_ready && word_bus.Word_Valid_I;
   assign count_next  = count_after + (refill ? MP2_COUNT_W'(MP2_WORD_W) : '0);

   mp2_shift_insert u_insert (
      .hold        (hold_q),
      .count_after (count_after),
      .shift_n     (shift_n),
      .word        (word_bus.Word_Data_I),
      .insert      (refill),
      .next_hold   (hold_next)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         hold_q          <= '0;
         count_q         <= '0;
         phase_q         <= '0;
         busy_q          <= 1'b1;
         Bits_Consumed_O <= '0;
         Shift_Error_O   <= 1'b0;
      end else if (Flush_I) begin
         hold_q          <= '0;
         count_q         <= '0;
         phase_q         <= '0;
         busy_q          <= 1'b1;
         Bits_Consumed_O <= '0;
      end else begin
         hold_q          <= hold_next;
         count_q         <= count_next;
         phase_q         <= phase_q + shift_n[2:0];
         busy_q          <= (count_next < MP2_COUNT_W'(MP2_WORD_W));
         Bits_Consumed_O <= Bits_Consumed_O + CNT_WIDTH'(shift_n);
         if (shift_bad)
            Shift_Error_O <= 1'b1;
      end
   end

   assign word_bus.Word_Ready_O = word_ready;
   assign Shift_Busy_O          = busy_q;
   assign Byte_Allign_O         = (phase_q == 3'd0);
   assign Bitstream_Data_O      = hold_q[MP2_HOLD_W-1 -: MP2_WORD_W];
   assign Empty_O               = busy_q && !word_bus.Word_Valid_I;
endmodule
